// File: rtl/counter_step_ctrl.sv
// Turns debounced up/down button levels plus a clear request into one-cycle inc/dec/clr commands.
// Press-and-hold auto-repeat is built only when AUTO_REPEAT_EN is defined.
module counter_step_ctrl #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned HOLD_CYCLES   = 50_000_000,
  parameter int unsigned REPEAT_CYCLES = 10_000_000,
  parameter bit          WRAP          = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             up_level,
  input  logic             down_level,
  input  logic             clr_req,
  input  logic [WIDTH-1:0] count_in,
  output logic             inc,
  output logic             dec,
  output logic             clr,
  output logic             active,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StHold    = 2'd1,
    StRepeat  = 2'd2,
    StWaitRel = 2'd3
  } state_e;

  if (HOLD_CYCLES < 2 || REPEAT_CYCLES < 2) begin : gen_param_check
    $error("counter_step_ctrl: HOLD_CYCLES and REPEAT_CYCLES must be at least 2");
  end

  state_e state_q, state_d;
  logic   inc_q, inc_d;
  logic   dec_q, dec_d;
  logic   clr_q, clr_d;
  logic   active_q, active_d;

  // At the limits the step is dropped but the sequencing carries on unchanged.
  logic inc_ok, dec_ok;
  assign inc_ok = WRAP || !(&count_in);
  assign dec_ok = WRAP || (|count_in);

`ifdef AUTO_REPEAT_EN
  localparam int unsigned MaxCycles  = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES
                                                                      : REPEAT_CYCLES;
  localparam int unsigned TimerW     = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;
  localparam logic [TimerW-1:0] HoldLoad   = TimerW'(HOLD_CYCLES - 1);
  localparam logic [TimerW-1:0] RepeatLoad = TimerW'(REPEAT_CYCLES - 1);

  logic [TimerW-1:0] timer_q, timer_d;
  logic              dir_q, dir_d;  // 0 = up, 1 = down
  logic              level_act;

  always_comb begin
    state_d   = state_q;
    inc_d     = 1'b0;
    dec_d     = 1'b0;
    clr_d     = 1'b0;
    timer_d   = timer_q;
    dir_d     = dir_q;
    level_act = dir_q ? down_level : up_level;

    if (clr_req) begin
      clr_d   = 1'b1;
      timer_d = '0;
      state_d = (up_level || down_level) ? StWaitRel : StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (up_level && down_level) begin
            state_d = StWaitRel;
          end else if (up_level) begin
            inc_d   = inc_ok;
            dir_d   = 1'b0;
            timer_d = HoldLoad;
            state_d = StHold;
          end else if (down_level) begin
            dec_d   = dec_ok;
            dir_d   = 1'b1;
            timer_d = HoldLoad;
            state_d = StHold;
          end
        end
        StHold, StRepeat: begin
          // The other button is ignored; only releasing the served one ends the press.
          if (!level_act) begin
            state_d = StIdle;
          end else if (timer_q != '0) begin
            timer_d = timer_q - TimerW'(1);
          end else begin
            inc_d   = !dir_q && inc_ok;
            dec_d   = dir_q && dec_ok;
            timer_d = RepeatLoad;
            state_d = StRepeat;
          end
        end
        StWaitRel: begin
          if (!up_level && !down_level) state_d = StIdle;
        end
        default: state_d = StWaitRel;
      endcase
    end

    active_d = (state_d == StHold) || (state_d == StRepeat);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      timer_q <= '0;
      dir_q   <= 1'b0;
    end else begin
      timer_q <= timer_d;
      dir_q   <= dir_d;
    end
  end
`else
  always_comb begin
    state_d  = state_q;
    inc_d    = 1'b0;
    dec_d    = 1'b0;
    clr_d    = 1'b0;
    active_d = 1'b0;

    if (clr_req) begin
      clr_d   = 1'b1;
      state_d = (up_level || down_level) ? StWaitRel : StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (up_level && down_level) begin
            state_d = StWaitRel;
          end else if (up_level) begin
            inc_d   = inc_ok;
            state_d = StWaitRel;
          end else if (down_level) begin
            dec_d   = dec_ok;
            state_d = StWaitRel;
          end
        end
        StWaitRel: begin
          if (!up_level && !down_level) state_d = StIdle;
        end
        default: state_d = StWaitRel;
      endcase
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StWaitRel;
      inc_q    <= 1'b0;
      dec_q    <= 1'b0;
      clr_q    <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      inc_q    <= inc_d;
      dec_q    <= dec_d;
      clr_q    <= clr_d;
      active_q <= active_d;
    end
  end

  assign inc    = inc_q;
  assign dec    = dec_q;
  assign clr    = clr_q;
  assign active = active_q;
  assign state  = state_q;

endmodule

// File: tb/tb_counter_step_ctrl.sv
// Directed bench for counter_step_ctrl (HOLD_CYCLES=10, REPEAT_CYCLES=4); a second instance
// with WRAP=1 covers the limit behaviour. Expectations follow AUTO_REPEAT_EN.
module tb_counter_step_ctrl;

`ifdef AUTO_REPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, up_level, down_level, clr_req;
  logic [7:0] count_in;
  logic       inc, dec, clr, active;
  logic [1:0] state;
  logic       inc_w, dec_w, clr_w, active_w;
  logic [1:0] state_w;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  counter_step_ctrl #(
    .WIDTH(8), .HOLD_CYCLES(10), .REPEAT_CYCLES(4), .WRAP(1'b0)
  ) u_dut (
    .clk(clk), .reset(reset), .up_level(up_level), .down_level(down_level),
    .clr_req(clr_req), .count_in(count_in), .inc(inc), .dec(dec), .clr(clr),
    .active(active), .state(state)
  );

  counter_step_ctrl #(
    .WIDTH(8), .HOLD_CYCLES(10), .REPEAT_CYCLES(4), .WRAP(1'b1)
  ) u_dut_wrap (
    .clk(clk), .reset(reset), .up_level(up_level), .down_level(down_level),
    .clr_req(clr_req), .count_in(count_in), .inc(inc_w), .dec(dec_w), .clr(clr_w),
    .active(active_w), .state(state_w)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs set after tick() apply to the current cycle; outputs read after tick() show the
  // decision taken in the previous cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic exp_b;
    reset = 1'b1; up_level = 1'b0; down_level = 1'b0; clr_req = 1'b0; count_in = 8'h10;
    tick();
    tick();
    chk("rst_state", state, 2'd3);
    chk("rst_inc", inc, 1'b0);
    chk("rst_dec", dec, 1'b0);
    chk("rst_clr", clr, 1'b0);
    chk("rst_active", active, 1'b0);
    reset = 1'b0;
    tick();
    chk("rst_idle", state, 2'd0);

    // Single-cycle press
    up_level = 1'b1;
    tick();
    up_level = 1'b0;
    chk("t1_inc", inc, 1'b1);
    chk("t1_dec", dec, 1'b0);
    chk("t1_clr", clr, 1'b0);
    chk("t1_state", state, AR ? 2'd1 : 2'd3);
    chk("t1_active", active, AR);
    tick();
    chk("t1_inc_off", inc, 1'b0);
    chk("t1_idle", state, 2'd0);

    // Held press: cycles t..t+29
    up_level = 1'b1;
    for (int k = 1; k <= 31; k++) begin
      tick();
      if (k == 30) up_level = 1'b0;
      if (AR) exp_b = (k == 1 || k == 11 || k == 15 || k == 19 || k == 23 || k == 27);
      else    exp_b = (k == 1);
      chk($sformatf("t2_inc_%0d", k), inc, exp_b);
      chk($sformatf("t2_dec_%0d", k), dec, 1'b0);
    end
    chk("t2_idle", state, 2'd0);

    // Limits
    count_in = 8'hFF;
    up_level = 1'b1;
    tick();
    up_level = 1'b0;
    chk("t3_inc_sat", inc, 1'b0);
    chk("t3_inc_wrap", inc_w, 1'b1);
    chk("t3_state_sat", state, AR ? 2'd1 : 2'd3);
    tick();
    count_in = 8'h00;
    down_level = 1'b1;
    tick();
    down_level = 1'b0;
    chk("t3_dec_sat", dec, 1'b0);
    chk("t3_dec_wrap", dec_w, 1'b1);
    tick();
    count_in = 8'h10;
    chk("t3_idle", state, 2'd0);

    // Simultaneous press
    up_level = 1'b1; down_level = 1'b1;
    tick();
    chk("t4_inc", inc, 1'b0);
    chk("t4_dec", dec, 1'b0);
    chk("t4_state", state, 2'd3);
    down_level = 1'b0;
    tick();
    chk("t4_hold_wait", state, 2'd3);
    chk("t4_inc2", inc, 1'b0);
    up_level = 1'b0;
    tick();
    chk("t4_idle", state, 2'd0);

    // Clear during a held press
    up_level = 1'b1;
    for (int k = 1; k <= 16; k++) tick();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    chk("t5_clr", clr, 1'b1);
    chk("t5_inc", inc, 1'b0);
    chk("t5_state", state, 2'd3);
    chk("t5_active", active, 1'b0);
    for (int k = 18; k <= 30; k++) begin
      tick();
      chk($sformatf("t5_noinc_%0d", k), inc, 1'b0);
      chk($sformatf("t5_clr_off_%0d", k), clr, 1'b0);
    end
    chk("t5_wait", state, 2'd3);
    up_level = 1'b0;
    tick();
    chk("t5_idle", state, 2'd0);

    // Reset during HOLD with the button still held
    up_level = 1'b1;
    for (int k = 1; k <= 5; k++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_inc", inc, 1'b0);
    chk("t6_state", state, 2'd3);
    chk("t6_active", active, 1'b0);
    for (int k = 7; k <= 25; k++) begin
      tick();
      chk($sformatf("t6_noinc_%0d", k), inc, 1'b0);
    end
    up_level = 1'b0;
    tick();
    chk("t6_idle", state, 2'd0);
    up_level = 1'b1;
    tick();
    up_level = 1'b0;
    chk("t6_repress", inc, 1'b1);
    tick();

    // Down press with up joining mid-press; up becomes a new press once down is released
    down_level = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (k == 5) up_level = 1'b1;
      if (k == 12) down_level = 1'b0;
      if (k == 14) up_level = 1'b0;
      exp_b = AR ? (k == 1 || k == 11) : (k == 1);
      chk($sformatf("t7_dec_%0d", k), dec, exp_b);
      exp_b = AR && (k == 14);
      chk($sformatf("t7_inc_%0d", k), inc, exp_b);
    end
    chk("t7_idle", state, 2'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
